// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered immediate generator between decode and register read.
//
// Extracts the immediate from instruction bits [31:7], sign- or zero-extends it
// to XLEN, and hands it downstream through a 2-entry skid buffer (output entry A
// plus skid entry B) with a side-band tag and an illegal-encoding flag.
//
// Ports:
//   clk_i          clock, rising edge
//   rst_ni         asynchronous active-low reset
//   flush_i        synchronous flush, drops every buffered entry
//   in_valid_i     upstream offers an instruction
//   in_ready_o     block can accept (registered)
//   in_i           instruction[31:7]
//   imm_sel_i      immediate type, see imm_sel_e
//   in_tag_i       side-band tag travelling with the entry
//   out_valid_o    out_imm_o / out_tag_o / out_illegal_o hold a valid entry
//   out_ready_i    downstream consumes the presented entry
//   out_imm_o      extended immediate
//   out_tag_o      tag of the presented entry
//   out_illegal_o  entry came from an illegal or reserved encoding
//   dbg_state_o    buffer occupancy state, for observation only
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// 1. The sender keeps its payload stable while valid=1 and ready=0. in_ready_o
// does not depend on in_valid_i or out_ready_i in the same cycle.

package imm_gen_pkg;
  // Shared immediate-type encodings; Z_TYPE takes the last free code.
  typedef enum logic [2:0] {
    U_TYPE          = 3'd0,
    J_TYPE          = 3'd1,
    S_TYPE          = 3'd2,
    B_TYPE          = 3'd3,
    I_SIGNED_TYPE   = 3'd4,
    I_SHIFT_TYPE    = 3'd5,
    I_UNSIGNED_TYPE = 3'd6,
    Z_TYPE          = 3'd7
  } imm_sel_e;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } buf_state_e;
endpackage

module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [24:0]      in_i,
  input  logic [2:0]       imm_sel_i,
  input  logic [TAG_W-1:0] in_tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [XLEN-1:0]  out_imm_o,
  output logic [TAG_W-1:0] out_tag_o,
  output logic             out_illegal_o,
  output buf_state_e       dbg_state_o
);

  // Indexed in instruction numbering so the rules read like the ISA manual.
  logic [31:7] instr;
  assign instr = in_i;

  // ---------------------------------------------------------------------------
  // Combinational extraction on the input side
  // ---------------------------------------------------------------------------
  logic [31:0]     v32;
  logic            sext;
  logic            ill_d;
  logic [XLEN-1:0] imm_d;

  always_comb begin
    v32   = '0;
    sext  = 1'b0;
    ill_d = 1'b0;
    case (imm_sel_i)
      U_TYPE:          begin v32 = {instr[31:12], 12'b0}; sext = 1'b1; end
      J_TYPE:          begin
        v32  = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
        sext = 1'b1;
      end
      S_TYPE:          begin
        v32  = {{21{instr[31]}}, instr[30:25], instr[11:7]};
        sext = 1'b1;
      end
      B_TYPE:          begin
        v32  = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
        sext = 1'b1;
      end
      I_SIGNED_TYPE:   begin v32 = {{21{instr[31]}}, instr[30:20]}; sext = 1'b1; end
      I_UNSIGNED_TYPE: v32 = {20'b0, instr[31:20]};
      I_SHIFT_TYPE: begin
        // RV32 has only 5-bit shift amounts; instr[25]=1 is reserved there.
        if (XLEN == 64)       v32 = {26'b0, instr[25:20]};
        else if (instr[25])   ill_d = 1'b1;
        else                  v32 = {27'b0, instr[24:20]};
      end
      Z_TYPE:          v32 = {27'b0, instr[19:15]};
      // Only reachable for X/unknown selects.
      default:         ill_d = 1'b1;
    endcase
    // Upper bits (RV64 only) replicate bit 31 for signed types, else zero.
    imm_d       = {XLEN{sext & v32[31]}};
    imm_d[31:0] = v32;
  end

  // ---------------------------------------------------------------------------
  // Skid buffer FSM: A is the output register, B the skid register
  // ---------------------------------------------------------------------------
  buf_state_e      state_q;
  logic            in_ready_q;
  logic            out_valid_q;
  logic [XLEN-1:0] a_imm_q, b_imm_q;
  logic [TAG_W-1:0] a_tag_q, b_tag_q;
  logic            a_ill_q, b_ill_q;

  logic accept, pop;
  assign accept = in_valid_i & in_ready_q;
  assign pop    = out_valid_q & out_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      a_imm_q     <= '0;
      a_tag_q     <= '0;
      a_ill_q     <= 1'b0;
      b_imm_q     <= '0;
      b_tag_q     <= '0;
      b_ill_q     <= 1'b0;
    end else if (flush_i) begin
      // Any same-cycle accept is dropped; a same-cycle pop was already taken.
      state_q     <= S_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (accept) begin
            a_imm_q     <= imm_d;
            a_tag_q     <= in_tag_i;
            a_ill_q     <= ill_d;
            state_q     <= S_ONE;
            out_valid_q <= 1'b1;
          end
        end
        S_ONE: begin
          if (accept && !pop) begin
            // A is stalled; park the newcomer in B and close the input.
            b_imm_q    <= imm_d;
            b_tag_q    <= in_tag_i;
            b_ill_q    <= ill_d;
            state_q    <= S_FULL;
            in_ready_q <= 1'b0;
          end else if (accept) begin
            a_imm_q <= imm_d;
            a_tag_q <= in_tag_i;
            a_ill_q <= ill_d;
          end else if (pop) begin
            state_q     <= S_EMPTY;
            out_valid_q <= 1'b0;
          end
        end
        S_FULL: begin
          // in_ready_q is 0 here, so only a pop can happen.
          if (pop) begin
            a_imm_q    <= b_imm_q;
            a_tag_q    <= b_tag_q;
            a_ill_q    <= b_ill_q;
            state_q    <= S_ONE;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= S_EMPTY;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready_o    = in_ready_q;
  assign out_valid_o   = out_valid_q;
  assign out_imm_o     = a_imm_q;
  assign out_tag_o     = a_tag_q;
  assign out_illegal_o = a_ill_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: an XLEN=32 and an XLEN=64 instance share one input
// stream; a queue-based FIFO model with arithmetic immediate rules predicts
// both.
module tb_imm_gen_pipe;
  import imm_gen_pkg::*;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [24:0] in_w = '0;
  logic [2:0]  sel = '0;
  logic [7:0]  tag = '0;

  logic        r32, v32, ill32, r64, v64, ill64;
  logic [31:0] imm32;
  logic [63:0] imm64;
  logic [7:0]  tag32, tag64;
  buf_state_e  st32, st64;

  imm_gen_pipe #(.XLEN(32), .TAG_W(8)) dut32 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .in_valid_i(in_valid),
    .in_ready_o(r32), .in_i(in_w), .imm_sel_i(sel), .in_tag_i(tag),
    .out_valid_o(v32), .out_ready_i(out_ready), .out_imm_o(imm32),
    .out_tag_o(tag32), .out_illegal_o(ill32), .dbg_state_o(st32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(8)) dut64 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .in_valid_i(in_valid),
    .in_ready_o(r64), .in_i(in_w), .imm_sel_i(sel), .in_tag_i(tag),
    .out_valid_o(v64), .out_ready_i(out_ready), .out_imm_o(imm64),
    .out_tag_o(tag64), .out_illegal_o(ill64), .dbg_state_o(st64)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [63:0] i32;
    logic [63:0] i64;
    logic        l32;
    logic        l64;
    logic [7:0]  tag;
  } ent_t;

  ent_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  bit   last_acc;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Immediate rules as plain integer arithmetic on the field values.
  function automatic void ref_imm(input logic [31:7] instr, input logic [2:0] s,
                                  input int xlen, output logic [63:0] imm,
                                  output logic ill);
    longint v;
    v   = 0;
    ill = 1'b0;
    case (s)
      U_TYPE: begin
        v = longint'(instr[31:12]) * 4096;
        if (instr[31]) v = v - (longint'(1) << 32);
      end
      J_TYPE: begin
        v = longint'({instr[31], instr[19:12], instr[20], instr[30:21]}) * 2;
        if (v >= (1 << 20)) v = v - (1 << 21);
      end
      B_TYPE: begin
        v = longint'({instr[31], instr[7], instr[30:25], instr[11:8]}) * 2;
        if (v >= 4096) v = v - 8192;
      end
      S_TYPE: begin
        v = longint'({instr[31:25], instr[11:7]});
        if (v >= 2048) v = v - 4096;
      end
      I_SIGNED_TYPE: begin
        v = longint'(instr[31:20]);
        if (v >= 2048) v = v - 4096;
      end
      I_UNSIGNED_TYPE: v = longint'(instr[31:20]);
      I_SHIFT_TYPE: begin
        if (xlen == 64)      v = longint'(instr[25:20]);
        else if (instr[25])  ill = 1'b1;
        else                 v = longint'(instr[24:20]);
      end
      Z_TYPE:  v = longint'(instr[19:15]);
      default: ill = 1'b1;
    endcase
    imm = (xlen == 32) ? (v & 64'hFFFF_FFFF) : v;
  endfunction

  function automatic buf_state_e exp_state(input int n);
    return (n == 0) ? S_EMPTY : (n == 1) ? S_ONE : S_FULL;
  endfunction

  task automatic check_outputs();
    check("in_ready32", 64'(r32), 64'(exp_q.size() < 2));
    check("in_ready64", 64'(r64), 64'(exp_q.size() < 2));
    check("out_valid32", 64'(v32), 64'(exp_q.size() > 0));
    check("out_valid64", 64'(v64), 64'(exp_q.size() > 0));
    check("state32", 64'(st32), 64'(exp_state(exp_q.size())));
    check("state64", 64'(st64), 64'(exp_state(exp_q.size())));
    if (exp_q.size() > 0) begin
      check("imm32", 64'(imm32), exp_q[0].i32);
      check("imm64", imm64, exp_q[0].i64);
      check("ill32", 64'(ill32), 64'(exp_q[0].l32));
      check("ill64", 64'(ill64), 64'(exp_q[0].l64));
      check("tag32", 64'(tag32), 64'(exp_q[0].tag));
      check("tag64", 64'(tag64), 64'(exp_q[0].tag));
    end
  endtask

  // Called at a negedge with inputs already driven: check, advance model, clock.
  task automatic cycle();
    ent_t e;
    bit   pop;
    check_outputs();
    pop      = (exp_q.size() > 0) && out_ready;
    last_acc = in_valid && (exp_q.size() < 2) && !flush;
    if (flush) begin
      exp_q.delete();
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (last_acc) begin
        ref_imm(in_w, sel, 32, e.i32, e.l32);
        ref_imm(in_w, sel, 64, e.i64, e.l64);
        e.tag = tag;
        exp_q.push_back(e);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic drive(input logic v, input logic [31:0] instr, input logic [2:0] s,
                       input logic [7:0] t, input logic rdy, input logic fl);
    in_valid  = v;
    in_w      = instr[31:7];
    sel       = s;
    tag       = t;
    out_ready = rdy;
    flush     = fl;
  endtask

  task automatic drain();
    drive(1'b0, 32'h0, U_TYPE, 8'h0, 1'b1, 1'b0);
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) cycle();
  endtask

  // One instruction through an empty buffer with known answers for both widths.
  task automatic directed(input string name, input logic [31:0] instr, input logic [2:0] s,
                          input logic [63:0] e32, input logic l32,
                          input logic [63:0] e64, input logic l64);
    drain();
    drive(1'b1, instr, s, 8'h3C, 1'b1, 1'b0);
    cycle();
    check({name, "_valid"}, 64'(v32 & v64), 64'(1));
    check({name, "_imm32"}, 64'(imm32), e32);
    check({name, "_ill32"}, 64'(ill32), 64'(l32));
    check({name, "_imm64"}, imm64, e64);
    check({name, "_ill64"}, 64'(ill64), 64'(l64));
    drain();
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [7:0] seen[$];
    int         idx;

    repeat (2) @(negedge clk);
    check("rst_valid32", 64'(v32), 64'(0));
    check("rst_ready32", 64'(r32), 64'(1));
    check("rst_imm32", 64'(imm32), 64'(0));
    check("rst_tag32", 64'(tag32), 64'(0));
    check("rst_ill32", 64'(ill32), 64'(0));
    check("rst_valid64", 64'(v64), 64'(0));
    check("rst_imm64", imm64, 64'(0));
    rst_n = 1'b1;

    // Known-answer instructions.
    directed("addi_m1", 32'hFFF0_0093, I_SIGNED_TYPE,
             64'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    directed("lui", 32'h8000_00B7, U_TYPE,
             64'h8000_0000, 1'b0, 64'hFFFF_FFFF_8000_0000, 1'b0);
    directed("slli33", 32'h0210_9093, I_SHIFT_TYPE,
             64'h0, 1'b1, 64'd33, 1'b0);
    directed("csrrwi", 32'h000F_D0F3, Z_TYPE,
             64'd31, 1'b0, 64'd31, 1'b0);
    directed("beq_m4096", 32'h8000_0063, B_TYPE,
             64'hFFFF_F000, 1'b0, 64'hFFFF_FFFF_FFFF_F000, 1'b0);
    directed("andi_u", 32'hFFF0_0093, I_UNSIGNED_TYPE,
             64'h0FFF, 1'b0, 64'h0FFF, 1'b0);
    directed("sw_m1", 32'hFE00_0FA3, S_TYPE,
             64'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    directed("jal_m2", 32'hFFFF_F0EF, J_TYPE,
             64'hFFFF_FFFE, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);

    // Back-pressure: tags 1..4 offered, downstream stalled for 3 cycles.
    idx = 0;
    for (int c = 0; c < 20 && seen.size() < 4; c++) begin
      drive(idx < 4, 32'h0010_0093, I_SIGNED_TYPE, 8'(idx + 1), c >= 3, 1'b0);
      if (c >= 1 && c <= 3) check("bp_tag_hold", 64'(tag32), 64'(1));
      if (c == 2 || c == 3) check("bp_in_ready", 64'(r32), 64'(0));
      if (v32 && out_ready) seen.push_back(tag32);
      cycle();
      if (last_acc) idx++;
    end
    check("bp_count", 64'(seen.size()), 64'(4));
    for (int i = 0; i < seen.size(); i++) check("bp_order", 64'(seen[i]), 64'(i + 1));
    drain();

    // Flush while FULL with a simultaneous offer.
    drive(1'b1, 32'h0010_0093, I_SIGNED_TYPE, 8'h11, 1'b0, 1'b0); cycle();
    drive(1'b1, 32'h0020_0093, I_SIGNED_TYPE, 8'h22, 1'b0, 1'b0); cycle();
    check("pre_flush_ready", 64'(r32), 64'(0));
    drive(1'b1, 32'h0030_0093, I_SIGNED_TYPE, 8'hAA, 1'b0, 1'b1); cycle();
    check("flush_valid", 64'(v32), 64'(0));
    check("flush_ready", 64'(r32), 64'(1));
    drive(1'b0, 32'h0, U_TYPE, 8'h0, 1'b1, 1'b0);
    repeat (3) cycle();

    // Randomized traffic.
    repeat (400) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_w      = 25'($urandom);
      sel       = 3'($urandom_range(0, 7));
      tag       = 8'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      cycle();
    end

    // Asynchronous reset mid-stream, sampled before the next rising edge.
    drain();
    drive(1'b1, 32'h0210_9093, I_SHIFT_TYPE, 8'h5A, 1'b0, 1'b0); cycle();
    drive(1'b1, 32'h0220_9093, I_SHIFT_TYPE, 8'h5B, 1'b0, 1'b0); cycle();
    check("pre_rst_valid", 64'(v32), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid32", 64'(v32), 64'(0));
    check("arst_ready32", 64'(r32), 64'(1));
    check("arst_imm32", 64'(imm32), 64'(0));
    check("arst_tag32", 64'(tag32), 64'(0));
    check("arst_ill32", 64'(ill32), 64'(0));
    check("arst_imm64", imm64, 64'(0));
    check("arst_tag64", 64'(tag64), 64'(0));
    exp_q.delete();
    drive(1'b0, 32'h0, U_TYPE, 8'h0, 1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    // B must have been cleared too: a fresh entry and nothing stale behind it.
    drive(1'b1, 32'h0070_0093, I_SIGNED_TYPE, 8'h77, 1'b0, 1'b0); cycle();
    drive(1'b0, 32'h0, U_TYPE, 8'h0, 1'b1, 1'b0);
    repeat (3) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
